// File: rtl/lsq_issue_unit_pkg.sv
// Shared RISC-V load encodings and CVA5 load-tracking types used by the LSQ issue unit.
// Both packages live here so the load-extension helper sees the fn3 codes it decodes.
package riscv_types;
    localparam logic [2:0] LS_B_FN3 = 3'b000;
    localparam logic [2:0] LS_H_FN3 = 3'b001;
    localparam logic [2:0] LS_W_FN3 = 3'b010;
    localparam logic [2:0] L_BU_FN3 = 3'b100;
    localparam logic [2:0] L_HU_FN3 = 3'b101;
endpackage

package cva5_types;
    import riscv_types::*;

    localparam int ID_WIDTH = 4;
    typedef logic [ID_WIDTH-1:0] id_t;

    typedef struct packed {
        id_t        id;
        logic [2:0] fn3;
        logic [1:0] offset;
    } load_attr_t;

    // Align the addressed bytes to bit 0, then sign/zero extend by access size.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  fn3,
                                                input logic [1:0]  offset);
        logic [31:0] shifted;
        shifted = word >> {offset, 3'b000};
        case (fn3)
            LS_B_FN3: return {{24{shifted[7]}}, shifted[7:0]};
            LS_H_FN3: return {{16{shifted[15]}}, shifted[15:0]};
            LS_W_FN3: return shifted;
            L_BU_FN3: return {24'h000000, shifted[7:0]};
            L_HU_FN3: return {16'h0000, shifted[15:0]};
            default:  return shifted;
        endcase
    endfunction
endpackage

// File: rtl/lsq_issue_unit_chk.sv
// Protocol checker for the LSQ issue unit: flags read responses with no load
// awaiting one, and responses arriving into a full, non-draining response queue.
module lsq_issue_unit_chk #(
    parameter int LOAD_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    input logic mem_req_valid,
    input logic mem_req_ready,
    input logic mem_load,
    input logic mem_rd_valid,
    input logic wb_valid,
    input logic wb_ack
);
    localparam logic [7:0] DEPTH_C = 8'(LOAD_DEPTH);

    logic [7:0] pending_r;
    logic [7:0] queued_r;
    logic       issue_s;
    logic       pop_s;

    assign issue_s = mem_req_valid && mem_req_ready && mem_load;
    assign pop_s   = wb_valid && wb_ack;

    // Track loads awaiting a response and responses awaiting writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= 8'd0;
            queued_r  <= 8'd0;
        end else begin
            assert (!(mem_rd_valid && (pending_r == 8'd0)));
            assert (!(mem_rd_valid && (queued_r == DEPTH_C) && !pop_s));
            pending_r <= pending_r + {7'd0, issue_s} - {7'd0, mem_rd_valid};
            queued_r  <= queued_r + {7'd0, mem_rd_valid} - {7'd0, pop_s};
        end
    end
endmodule

// File: rtl/lsq_issue_unit_fifo.sv
// Small power-of-two FIFO with a combinational head; a push is accepted while
// full when a pop happens in the same cycle.
module cva5_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]         rd_ptr_r;
    logic [PW-1:0]         wr_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  full_s;
    logic                  do_pop_s;
    logic                  do_push_s;

    assign valid     = (count_r != {CW{1'b0}});
    assign full_s    = (count_r == DEPTH_C);
    assign do_pop_s  = pop && valid;
    assign do_push_s = push && (!full_s || do_pop_s);
    assign data_out  = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy gates the head.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= data_in;
    end
endmodule

// File: rtl/lsq_issue_unit.sv
// Issues load/store queue heads to the memory subunits, bounds outstanding loads,
// and returns in-order load responses as extended writebacks.
module lsq_issue_unit
    import cva5_types::*;
#(
    parameter int LOAD_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsq_valid,
    output logic        lsq_pop,
    input  logic [31:0] lsq_addr,
    input  logic        lsq_load,
    input  logic        lsq_store,
    input  logic [3:0]  lsq_be,
    input  logic [2:0]  lsq_fn3,
    input  logic [31:0] lsq_data,
    input  id_t         lsq_id,
    input  logic [1:0]  lsq_subunit_id,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_load,
    output logic        mem_store,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_data,
    output logic [1:0]  mem_subunit_id,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rd_data,
    output logic        wb_valid,
    input  logic        wb_ack,
    output id_t         wb_id,
    output logic [31:0] wb_data
);
    localparam int CW = $clog2(LOAD_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(LOAD_DEPTH);

    logic [CW-1:0] cnt_r;
    logic          load_issue_s;
    logic          wb_pop_s;
    logic          attr_valid_s;
    logic          resp_valid_s;
    load_attr_t    attr_in_s;
    load_attr_t    attr_head_s;
    logic [31:0]   resp_head_s;

    // Only loads (including fused load/store entries) are held back at full.
    assign mem_req_valid  = lsq_valid && (!lsq_load || (cnt_r < DEPTH_C));
    assign lsq_pop        = mem_req_valid && mem_req_ready;
    assign mem_addr       = lsq_addr;
    assign mem_load       = lsq_load;
    assign mem_store      = lsq_store;
    assign mem_be         = lsq_be;
    assign mem_data       = lsq_data;
    assign mem_subunit_id = lsq_subunit_id;

    assign load_issue_s = lsq_pop && lsq_load;
    assign wb_pop_s     = wb_valid && wb_ack;
    assign attr_in_s    = {lsq_id, lsq_fn3, lsq_addr[1:0]};

    assign wb_valid = resp_valid_s && attr_valid_s;
    assign wb_id    = attr_head_s.id;
    assign wb_data  = load_extend(resp_head_s, attr_head_s.fn3, attr_head_s.offset);

    // Outstanding load count: issue adds one, writeback handshake retires one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            case ({load_issue_s, wb_pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1'b1);
                2'b01:   cnt_r <= cnt_r - CW'(1'b1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    cva5_fifo #(
        .DATA_WIDTH ($bits(load_attr_t)),
        .DEPTH      (LOAD_DEPTH)
    ) u_attr_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (load_issue_s),
        .pop      (wb_pop_s),
        .data_in  (attr_in_s),
        .data_out (attr_head_s),
        .valid    (attr_valid_s)
    );

    cva5_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (LOAD_DEPTH)
    ) u_resp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (mem_rd_valid),
        .pop      (wb_pop_s),
        .data_in  (mem_rd_data),
        .data_out (resp_head_s),
        .valid    (resp_valid_s)
    );
endmodule

// File: tb/tb_lsq_issue_unit.sv
// Directed bench for lsq_issue_unit: issue gating, pass-through, writeback
// ordering/extension, full-depth behaviour and reset recovery.
module tb_lsq_issue_unit;
    import cva5_types::*;

    localparam int LOAD_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsq_valid;
    logic        lsq_pop;
    logic [31:0] lsq_addr;
    logic        lsq_load;
    logic        lsq_store;
    logic [3:0]  lsq_be;
    logic [2:0]  lsq_fn3;
    logic [31:0] lsq_data;
    id_t         lsq_id;
    logic [1:0]  lsq_subunit_id;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_load;
    logic        mem_store;
    logic [3:0]  mem_be;
    logic [31:0] mem_data;
    logic [1:0]  mem_subunit_id;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic        wb_valid;
    logic        wb_ack;
    id_t         wb_id;
    logic [31:0] wb_data;

    int tests = 0;
    int fails = 0;

    logic [1:0]  ext_off [5] = '{2'd2, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [2:0]  ext_fn3 [5] = '{3'b001, 3'b100, 3'b101, 3'b000, 3'b011};
    logic [31:0] ext_rd  [5] = '{32'h80011234, 32'h0000F200, 32'hABCD0000, 32'h0000007F, 32'hDEADBEEF};
    logic [31:0] ext_exp [5] = '{32'hFFFF8001, 32'h000000F2, 32'h0000ABCD, 32'h0000007F, 32'hDEADBEEF};
    logic [31:0] fill_rd [3] = '{32'h22222222, 32'h33333333, 32'h44444444};

    always #5 clk = ~clk;

    lsq_issue_unit #(.LOAD_DEPTH(LOAD_DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .lsq_valid      (lsq_valid),
        .lsq_pop        (lsq_pop),
        .lsq_addr       (lsq_addr),
        .lsq_load       (lsq_load),
        .lsq_store      (lsq_store),
        .lsq_be         (lsq_be),
        .lsq_fn3        (lsq_fn3),
        .lsq_data       (lsq_data),
        .lsq_id         (lsq_id),
        .lsq_subunit_id (lsq_subunit_id),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_load       (mem_load),
        .mem_store      (mem_store),
        .mem_be         (mem_be),
        .mem_data       (mem_data),
        .mem_subunit_id (mem_subunit_id),
        .mem_rd_valid   (mem_rd_valid),
        .mem_rd_data    (mem_rd_data),
        .wb_valid       (wb_valid),
        .wb_ack         (wb_ack),
        .wb_id          (wb_id),
        .wb_data        (wb_data)
    );

    lsq_issue_unit_chk #(.LOAD_DEPTH(LOAD_DEPTH)) chk_i (
        .clk           (clk),
        .rst           (rst),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_load      (mem_load),
        .mem_rd_valid  (mem_rd_valid),
        .wb_valid      (wb_valid),
        .wb_ack        (wb_ack)
    );

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input logic ld, input logic st, input logic [31:0] addr,
                        input logic [2:0] fn3, input id_t id, input logic [3:0] be,
                        input logic [31:0] data);
        lsq_valid = 1'b1;
        lsq_load  = ld;
        lsq_store = st;
        lsq_addr  = addr;
        lsq_fn3   = fn3;
        lsq_id    = id;
        lsq_be    = be;
        lsq_data  = data;
    endtask

    initial begin
        rst = 1'b1;
        lsq_valid = 1'b0; lsq_addr = 32'h0; lsq_load = 1'b0; lsq_store = 1'b0;
        lsq_be = 4'h0; lsq_fn3 = 3'b000; lsq_data = 32'h0; lsq_id = '0;
        lsq_subunit_id = 2'd0; mem_req_ready = 1'b1; mem_rd_valid = 1'b0;
        mem_rd_data = 32'h0; wb_ack = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk1("rst_wb_valid", wb_valid, 1'b0);
        chk1("rst_req_valid", mem_req_valid, 1'b0);
        chk1("rst_pop", lsq_pop, 1'b0);

        // Byte load at offset 3, sign-extended, one cycle after the response
        head(1'b1, 1'b0, 32'h00001003, 3'b000, 4'd5, 4'h0, 32'h0);
        lsq_subunit_id = 2'd2;
        #1;
        chk1("lb_req_valid", mem_req_valid, 1'b1);
        chk1("lb_pop", lsq_pop, 1'b1);
        chk32("lb_addr", mem_addr, 32'h00001003);
        chk1("lb_mem_load", mem_load, 1'b1);
        chk32("lb_subunit", 32'(mem_subunit_id), 32'd2);
        tick();
        lsq_valid = 1'b0;
        mem_rd_valid = 1'b1; mem_rd_data = 32'h80FFFFFF;
        #1;
        chk1("lb_wb_not_yet", wb_valid, 1'b0);
        tick();
        mem_rd_valid = 1'b0;
        #1;
        chk1("lb_wb_valid", wb_valid, 1'b1);
        chk32("lb_wb_id", 32'(wb_id), 32'd5);
        chk32("lb_wb_data", wb_data, 32'hFFFFFF80);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        #1;
        chk1("lb_wb_done", wb_valid, 1'b0);

        // Store stalled by the subunit for three cycles
        head(1'b0, 1'b1, 32'h00000100, 3'b010, 4'd0, 4'b0011, 32'h0000BEEF);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("st_stall_pop", lsq_pop, 1'b0);
            chk1("st_stall_valid", mem_req_valid, 1'b1);
            tick();
        end
        mem_req_ready = 1'b1;
        #1;
        chk1("st_pop", lsq_pop, 1'b1);
        chk32("st_be", 32'(mem_be), 32'h3);
        chk32("st_data", mem_data, 32'h0000BEEF);
        chk1("st_mem_store", mem_store, 1'b1);
        tick();
        lsq_valid = 1'b0;

        // Fill to LOAD_DEPTH loads with no responses (also shows the store left cnt at 0)
        for (int i = 0; i < 4; i++) begin
            head(1'b1, 1'b0, 32'h00002000 + 32'(4 * i), 3'b010, 4'(i + 1), 4'h0, 32'h0);
            #1;
            chk1("fill_req_valid", mem_req_valid, 1'b1);
            tick();
        end
        head(1'b1, 1'b0, 32'h00003000, 3'b010, 4'd6, 4'h0, 32'h0);
        #1;
        chk1("full_load_blocked", mem_req_valid, 1'b0);
        chk1("full_load_no_pop", lsq_pop, 1'b0);
        tick();
        head(1'b0, 1'b1, 32'h00005000, 3'b010, 4'd0, 4'hF, 32'h5A5A5A5A);
        #1;
        chk1("full_store_valid", mem_req_valid, 1'b1);
        chk1("full_store_pop", lsq_pop, 1'b1);
        tick();
        head(1'b1, 1'b0, 32'h00003000, 3'b010, 4'd6, 4'h0, 32'h0);
        mem_rd_valid = 1'b1; mem_rd_data = 32'h11111111;
        #1;
        chk1("full_still_blocked", mem_req_valid, 1'b0);
        tick();
        mem_rd_valid = 1'b0;
        #1;
        chk32("full_wb_id1", 32'(wb_id), 32'd1);
        chk32("full_wb_data1", wb_data, 32'h11111111);
        wb_ack = 1'b1;
        #1;
        chk1("full_blocked_during_ack", mem_req_valid, 1'b0);
        tick();
        wb_ack = 1'b0;
        #1;
        chk1("full_reissue_valid", mem_req_valid, 1'b1);
        chk1("full_reissue_pop", lsq_pop, 1'b1);
        tick();
        lsq_valid = 1'b0;

        // Outstanding ids 2,3,4,6; queue three responses and hold writeback
        for (int i = 0; i < 3; i++) begin
            mem_rd_valid = 1'b1; mem_rd_data = fill_rd[i];
            tick();
        end
        mem_rd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk1("hold_wb_valid", wb_valid, 1'b1);
            chk32("hold_wb_id", 32'(wb_id), 32'd2);
            chk32("hold_wb_data", wb_data, 32'h22222222);
            tick();
        end
        mem_rd_valid = 1'b1; mem_rd_data = 32'h66666666; wb_ack = 1'b1;
        #1;
        chk32("drain_id2", 32'(wb_id), 32'd2);
        tick();
        mem_rd_valid = 1'b0;
        #1;
        chk32("drain_id3", 32'(wb_id), 32'd3);
        chk32("drain_data3", wb_data, 32'h33333333);
        tick();
        chk32("drain_id4", 32'(wb_id), 32'd4);
        chk32("drain_data4", wb_data, 32'h44444444);
        tick();
        chk32("drain_id6", 32'(wb_id), 32'd6);
        chk32("drain_data6", wb_data, 32'h66666666);
        tick();
        wb_ack = 1'b0;
        #1;
        chk1("drain_empty", wb_valid, 1'b0);

        // Fused load/store entry
        head(1'b1, 1'b1, 32'h00004000, 3'b010, 4'd2, 4'hF, 32'hAAAA5555);
        #1;
        chk1("fused_load", mem_load, 1'b1);
        chk1("fused_store", mem_store, 1'b1);
        chk32("fused_be", 32'(mem_be), 32'hF);
        chk32("fused_data", mem_data, 32'hAAAA5555);
        chk1("fused_pop", lsq_pop, 1'b1);
        tick();
        lsq_valid = 1'b0;
        mem_rd_valid = 1'b1; mem_rd_data = 32'h12345678;
        tick();
        mem_rd_valid = 1'b0;
        #1;
        chk32("fused_wb_id", 32'(wb_id), 32'd2);
        chk32("fused_wb_data", wb_data, 32'h12345678);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;

        // Size/sign extension across offsets
        for (int i = 0; i < 5; i++) begin
            head(1'b1, 1'b0, {30'h00001800, ext_off[i]}, ext_fn3[i], 4'(i + 8), 4'h0, 32'h0);
            tick();
            lsq_valid = 1'b0;
            mem_rd_valid = 1'b1; mem_rd_data = ext_rd[i];
            tick();
            mem_rd_valid = 1'b0;
            #1;
            chk32("ext_wb_data", wb_data, ext_exp[i]);
            chk32("ext_wb_id", 32'(wb_id), 32'(i + 8));
            wb_ack = 1'b1;
            tick();
            wb_ack = 1'b0;
        end

        // Reset with three loads in flight
        for (int i = 0; i < 3; i++) begin
            head(1'b1, 1'b0, 32'h00007000, 3'b010, 4'(i + 1), 4'h0, 32'h0);
            tick();
        end
        lsq_valid = 1'b0;
        mem_rd_valid = 1'b1; mem_rd_data = 32'hCAFEF00D;
        tick();
        mem_rd_valid = 1'b0;
        #1;
        chk1("pre_rst_wb_valid", wb_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk1("post_rst_wb_valid", wb_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            head(1'b1, 1'b0, 32'h00008000, 3'b010, 4'(i + 1), 4'h0, 32'h0);
            #1;
            chk1("post_rst_issue", mem_req_valid, 1'b1);
            tick();
        end
        #1;
        chk1("post_rst_full", mem_req_valid, 1'b0);
        lsq_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lsq_issue_unit.md
LSQ_ISSUE_UNIT -- requirements
Module: lsq_issue_unit

Interface
REQ-001 SHALL have parameter LOAD_DEPTH, default 4, max loads issued but not yet written back (power of two, >=2).
REQ-002 SHALL have ports, in this order:
- clk  in  1  clock; one clock only.
- rst  in  1  synchronous, active-high reset.
- lsq_valid  in  1  queue head valid.
- lsq_pop  out  1  consume queue head.
- lsq_addr  in  32  head address.
- lsq_load  in  1  head is a load.
- lsq_store  in  1  head is a store.
- lsq_be  in  4  store byte enables.
- lsq_fn3  in  3  access size/sign.
- lsq_data  in  32  store data, already lane-aligned.
- lsq_id  in  id_t  load id.
- lsq_subunit_id  in  2  target subunit.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  subunit accepts.
- mem_addr  out  32  address.
- mem_load  out  1  read.
- mem_store  out  1  write.
- mem_be  out  4  byte enables.
- mem_data  out  32  write data.
- mem_subunit_id  out  2  subunit select.
- mem_rd_valid  in  1  in-order read response.
- mem_rd_data  in  32  raw response word.
- wb_valid  out  1  writeback valid.
- wb_ack  in  1  writeback accepted.
- wb_id  out  id_t  writeback id.
- wb_data  out  32  extended load result.

Function
REQ-003 SHALL keep outstanding counter cnt (0..LOAD_DEPTH): +1 on load issue, -1 on writeback handshake; both in one cycle leaves cnt unchanged.
REQ-004 SHALL drive mem_req_valid = lsq_valid && (!lsq_load || cnt < LOAD_DEPTH), combinationally.
REQ-005 SHALL drive lsq_pop = mem_req_valid && mem_req_ready; no pop without handshake.
REQ-006 SHALL pass lsq_addr/load/store/be/data/subunit_id to mem_* unchanged and combinationally.
REQ-007 SHALL issue stores (lsq_load=0) when cnt == LOAD_DEPTH; only loads block at full.
REQ-008 SHALL treat fused entries (load=1, store=1) as loads for tracking, forwarding be and data.
REQ-009 SHALL push {id, fn3, addr[1:0]} into an attribute FIFO on every issued load.
REQ-010 SHALL push mem_rd_data into a response FIFO (depth LOAD_DEPTH) every cycle mem_rd_valid=1; responses are never back-pressured.
REQ-011 SHALL assert wb_valid when the response FIFO is non-empty; a response at cycle N gives wb_valid at N+1.
REQ-012 SHALL pop both FIFOs together on wb_valid && wb_ack; wb_valid/id/data hold while unacknowledged.
REQ-013 SHALL form wb_data from head response, shifted right by 8*offset: fn3 000 sign-extend byte, 001 sign-extend half, 010 full word, 100 zero-extend byte, 101 zero-extend half; other codes full word.
REQ-014 SHALL accept a response in the same cycle a writeback pops at full occupancy.
REQ-015 SHALL treat mem_rd_valid with no tracked load, or response overflow, as an error (assertion); no defined output.

Reset
REQ-016 SHALL on rst clear cnt and both FIFOs and deassert wb_valid the next cycle; mem_req_valid follows lsq_valid with cnt=0.
REQ-017 SHALL discard in-flight loads on reset mid-operation; responses after reset fall under REQ-015.

Structure
REQ-018 SHALL define the attribute struct (id_t id, fn3, 2-bit offset) in cva5_types; fn3 load encodings in riscv_types.
REQ-019 SHALL instantiate cva5_fifo for both attribute and response FIFOs; no other sub-module.

Verification
REQ-020 Load 0x1003, fn3=000, id=5; response 0x80FF_FF_FF -> wb_id=5, wb_data=0xFFFFFF80, one cycle after response.
REQ-021 Four loads, mem_rd_valid withheld -> 5th load: mem_req_valid=0; store behind it issues; one wb_ack -> 5th issues next cycle.
REQ-022 Store be=0011, data 0x0000BEEF, mem_req_ready low 3 cycles -> lsq_pop=0 for 3 cycles, then one pop; cnt stays 0.
REQ-023 Full, wb_ack=0 10 cycles -> wb_id/wb_data stable; simultaneous response and ack at full -> no overflow, order kept.
REQ-024 rst with 3 loads pending -> wb_valid=0 and cnt=0 next cycle; new load issues immediately.
REQ-025 Fused entry, be=1111, fn3=010, id=2, response 0x12345678 -> mem_load=mem_store=1, wb_data=0x12345678, wb_id=2.
